controller_leds_scan_pio: RTL and testbench
===========================================

# controller_leds_scan_pio

Parametrised Avalon-MM output port that holds CHANNELS independent WIDTH-bit LED select words and drives one of them onto `out_port` at a time. A channel is chosen either statically by register or by a programmable-rate scan sequencer that walks all channels. It sits on the controller's memory-mapped bus in place of single-word LED select ports and feeds the LED boost/bar multiplexing logic.

## Interface
Parameters:
- WIDTH, 6, bits per channel word and width of `out_port`
- CHANNELS, 4, number of channel words (2..252)
- AW, 3, Avalon word-address width; CHANNELS <= 2**AW - 4
- DIV_W, 16, prescaler/divider width

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- address  in  AW  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data, zero-wait
- out_port  out  WIDTH  registered selected channel word
- out_chan  out  8  registered index of the channel on `out_port`
- frame_strobe  out  1  one-cycle pulse when the scan wraps to channel 0

## Operation
- Register map (word offsets):
  - 0 CTRL: bit0 EN (scan enable), bit1 BLANK, bits[15:8] SEL (static channel)
  - 1 DIV: bits[DIV_W-1:0], channel dwell = DIV+1 cycles
  - 2 STATUS: bits[7:0] current channel (RO); bit8 FRAME (sticky, write-1-to-clear)
  - 3 reserved: reads 0, writes ignored
  - 4..4+CHANNELS-1 DATA[i]: bits[WIDTH-1:0]
- Write occurs when chipselect && !write_n; unused writedata bits are ignored; unmapped reads return 0; all readdata bits above the field width are 0.
- Scan (EN=1): prescaler counts 0..DIV. At terminal count, it clears and the channel advances; CHANNELS-1 wraps to 0, pulses frame_strobe and sets FRAME. DIV=0 advances every cycle.
- Static (EN=0): channel = SEL and the prescaler is held at 0. SEL >= CHANNELS forces out_port = 0, and out_chan reports SEL.
- Writing EN from 0 to 1 clears the prescaler and starts the scan at the current SEL; an out-of-range SEL starts at 0.
- BLANK=1 forces out_port = 0. Scanning continues underneath.
- Writing DIV clears the prescaler. If the write coincides with terminal count, the write wins and the channel does not advance that cycle.
- If a FRAME set and a W1C arrive in the same cycle, the set wins.

## Timing
- Reset values: every register is 0, so out_port=0, out_chan=0, frame_strobe=0, and readdata reflects zeroed registers.
- A DATA/CTRL write at edge N is visible on out_port/out_chan after edge N+1, giving 1-cycle output latency.
- readdata is combinational from address and current register state, with no wait states.
- In scan mode, each channel stays on out_port for exactly DIV+1 cycles, and a full frame lasts CHANNELS*(DIV+1) cycles.
- frame_strobe is registered and is high in the same cycle that out_chan first shows 0 after a wrap.
- Reset asserted mid-scan returns all state to reset values on the next edge; no partial frame_strobe is produced.

## Structure
- Package `controller_leds_pkg`: register offsets (CTRL, DIV, STATUS, DATA_BASE), CTRL/STATUS bit positions, and the channel index width constant (8).
- Sub-module `controller_leds_prescaler`: DIV_W counter with clear, enable and terminal-count tick. The top level holds the register file, channel sequencer, output mux and register stage.

## Test plan
- After reset: read all offsets and expect 0; out_port=0 and out_chan=0.
- Static mode: write DATA[2]=0x2A and CTRL.SEL=2, EN=0. Expect out_port=0x2A and out_chan=2 one cycle after the CTRL write. Then set SEL=9 and expect out_port=0.
- Scan mode: load DATA[0..3]=0x01,0x02,0x04,0x08, set DIV=2 and EN=1. Expect each value for 3 cycles, in order 0,1,2,3,0. frame_strobe pulses once per 12 cycles and STATUS.FRAME=1; writing 0x100 to STATUS clears it.
- Boundaries: with DIV=0, the channel advances every cycle. Write DIV=5 exactly on a terminal-count cycle and expect no advance on that cycle, then a 6-cycle dwell. Set FRAME and W1C in the same cycle and expect FRAME to stay 1.
- BLANK and reset: set BLANK during a scan and expect out_port=0 while out_chan keeps advancing. Assert reset mid-frame for 1 cycle and expect all outputs 0 with no frame_strobe.

Source files
------------

// File: rtl/controller_leds_pkg.sv
// Shared constants for the LED scan PIO: register word offsets, field bit
// positions and the channel index width used on out_chan and in STATUS.
package controller_leds_pkg;

    // Width of every channel index (out_chan, CTRL.SEL, STATUS channel field).
    localparam int unsigned CHAN_W = 8;

    // Register word offsets on the Avalon bus.
    localparam int unsigned REG_CTRL      = 0;
    localparam int unsigned REG_DIV       = 1;
    localparam int unsigned REG_STATUS    = 2;
    localparam int unsigned REG_DATA_BASE = 4;

    // CTRL field positions.
    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_BLANK_BIT = 1;
    localparam int unsigned CTRL_SEL_LSB   = 8;

    // STATUS field positions.
    localparam int unsigned STATUS_CHAN_LSB  = 0;
    localparam int unsigned STATUS_FRAME_BIT = 8;

    // True when a channel index addresses an existing DATA word.
    function automatic logic chan_in_range(input logic [CHAN_W-1:0] chan,
                                           input int unsigned channels);
        return (32'(chan) < channels);
    endfunction

endpackage

// File: rtl/controller_leds_prescaler.sv
// Dwell-time prescaler: counts 0..div and emits a one-cycle tick on the
// terminal count. A clear forces the count back to 0 and suppresses the tick,
// so a clear that lands on the terminal count cancels that cycle's advance.
module controller_leds_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic             at_term;

    assign at_term = (count == div);
    assign tick    = enable && !clear && at_term;

    // Count register: clear dominates, otherwise wrap at the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (at_term) begin
                count <= '0;
            end else begin
                count <= count + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/controller_leds_scan_pio.sv
// Avalon-MM LED select port holding CHANNELS words. One word is driven on
// out_port at a time, picked either statically by CTRL.SEL or by a scan
// sequencer that walks all channels with a programmable dwell of DIV+1 cycles.
//
// Bus handshake: a write is accepted in any cycle with chipselect high and
// write_n low (no wait states); readdata is a pure function of address and the
// current register state, valid in the same cycle.
module controller_leds_scan_pio
    import controller_leds_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 4,
    parameter int AW       = 3,
    parameter int DIV_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic [7:0]       out_chan,
    output logic             frame_strobe
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic              ctrl_en;
    logic              ctrl_blank;
    logic [CHAN_W-1:0] ctrl_sel;
    logic [DIV_W-1:0]  div_reg;
    logic              frame_flag;
    logic [WIDTH-1:0]  data [CHANNELS];

    // Sequencer state
    logic [CHAN_W-1:0] scan_chan;
    logic              wrap_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]       addr_w;
    logic              bus_wr;
    logic              ctrl_wr;
    logic              div_wr;
    logic              status_wr;
    logic              wd_en;
    logic [CHAN_W-1:0] wd_sel;
    logic              en_rise;
    logic              unused_wdata;

    assign addr_w    = 32'(address);
    assign bus_wr    = chipselect && !write_n;
    assign ctrl_wr   = bus_wr && (addr_w == REG_CTRL);
    assign div_wr    = bus_wr && (addr_w == REG_DIV);
    assign status_wr = bus_wr && (addr_w == REG_STATUS);

    assign wd_en   = writedata[CTRL_EN_BIT];
    assign wd_sel  = writedata[CTRL_SEL_LSB +: CHAN_W];
    // Scan starts only on a 0->1 transition of EN; rewriting EN=1 keeps the scan going.
    assign en_rise = ctrl_wr && wd_en && !ctrl_en;

    // Bits of writedata outside every field are deliberately ignored.
    assign unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // Prescaler: held at 0 in static mode, restarted by any DIV write.
    // An EN rise comes from static mode, where the count is already 0.
    // ------------------------------------------------------------------
    logic tick;
    logic presc_clear;
    logic wrap;

    assign presc_clear = !ctrl_en || div_wr;

    controller_leds_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (ctrl_en),
        .div    (div_reg),
        .tick   (tick)
    );

    assign wrap = tick && (scan_chan == CHAN_W'(CHANNELS - 1));

    // ------------------------------------------------------------------
    // Register file writes; a FRAME set outranks a same-cycle W1C.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en    <= 1'b0;
            ctrl_blank <= 1'b0;
            ctrl_sel   <= '0;
            div_reg    <= '0;
            frame_flag <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (ctrl_wr) begin
                ctrl_en    <= wd_en;
                ctrl_blank <= writedata[CTRL_BLANK_BIT];
                ctrl_sel   <= wd_sel;
            end
            if (div_wr) begin
                div_reg <= writedata[DIV_W-1:0];
            end
            if (wrap) begin
                frame_flag <= 1'b1;
            end else if (status_wr && writedata[STATUS_FRAME_BIT]) begin
                frame_flag <= 1'b0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus_wr && (addr_w == 32'(REG_DATA_BASE + i))) begin
                    data[i] <= writedata[WIDTH-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan sequencer: load the start channel on EN rise, advance on tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_chan <= '0;
        end else if (en_rise) begin
            scan_chan <= chan_in_range(wd_sel, CHANNELS) ? wd_sel : '0;
        end else if (tick) begin
            if (wrap) begin
                scan_chan <= '0;
            end else begin
                scan_chan <= scan_chan + CHAN_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel selection and output mux
    // ------------------------------------------------------------------
    logic [CHAN_W-1:0] cur_chan;
    logic [WIDTH-1:0]  sel_word;
    logic [WIDTH-1:0]  port_next;

    assign cur_chan = ctrl_en ? scan_chan : ctrl_sel;

    // Pick the DATA word addressed by the current channel (0 when out of range).
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cur_chan == CHAN_W'(i)) begin
                sel_word = data[i];
            end
        end
    end

    assign port_next = (ctrl_blank || !chan_in_range(cur_chan, CHANNELS)) ? '0 : sel_word;

    // Output stage; frame_strobe is delayed one extra cycle so it lines up
    // with the first cycle out_chan shows channel 0 after a wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port     <= '0;
            out_chan     <= '0;
            wrap_d       <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            out_port     <= port_next;
            out_chan     <= cur_chan;
            wrap_d       <= wrap;
            frame_strobe <= wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: zero-wait, unmapped offsets and unused bits read as 0.
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        if (addr_w == REG_CTRL) begin
            readdata[CTRL_EN_BIT]              = ctrl_en;
            readdata[CTRL_BLANK_BIT]           = ctrl_blank;
            readdata[CTRL_SEL_LSB +: CHAN_W]   = ctrl_sel;
        end else if (addr_w == REG_DIV) begin
            readdata[DIV_W-1:0]                = div_reg;
        end else if (addr_w == REG_STATUS) begin
            readdata[STATUS_CHAN_LSB +: CHAN_W] = cur_chan;
            readdata[STATUS_FRAME_BIT]          = frame_flag;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (addr_w == 32'(REG_DATA_BASE + i)) begin
                readdata[WIDTH-1:0] = data[i];
            end
        end
    end

endmodule

// File: tb/tb_controller_leds_scan_pio.sv
// Directed + randomized bench for controller_leds_scan_pio. Expected scan
// behaviour comes from a closed-form model: after a scan (re)start with
// prescaler at 0, the channel shown t cycles later is
// (start + (t-1)/(DIV+1)) mod CHANNELS.
module tb_controller_leds_scan_pio;

    localparam int WIDTH    = 6;
    localparam int CHANNELS = 4;
    localparam int AW       = 3;
    localparam int DIV_W    = 16;
    localparam int QW       = 1 + 8 + WIDTH;

    localparam logic [AW-1:0] A_CTRL   = AW'(0);
    localparam logic [AW-1:0] A_DIV    = AW'(1);
    localparam logic [AW-1:0] A_STATUS = AW'(2);

    logic             clk;
    logic             reset;
    logic [AW-1:0]    address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic [7:0]       out_chan;
    logic             frame_strobe;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] data_model [CHANNELS];
    logic [QW-1:0]    exp_q [$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    controller_leds_scan_pio #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .AW       (AW),
        .DIV_W    (DIV_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .out_port     (out_port),
        .out_chan     (out_chan),
        .frame_strobe (frame_strobe)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a clock edge; the write is captured on the next edge.
    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
        address    = '0;
    endtask

    task automatic write_data(input int idx, input logic [31:0] d);
        bus_write(AW'(4 + idx), d);
        data_model[idx] = d[WIDTH-1:0];
    endtask

    // Reads in the current cycle (sampled at the falling edge), then realigns.
    task automatic read_check(input logic [AW-1:0] a, input logic [31:0] exp_v, input string tag);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        check(tag, readdata, exp_v);
        chipselect = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for a scan started (or restarted) on the edge just passed.
    task automatic run_scan_check(input int start, input int dv, input int cycles,
                                  input bit blank, input string tag);
        logic [QW-1:0] e;
        for (int t = 1; t <= cycles; t++) begin
            int k;
            int ch;
            logic stb;
            logic [WIDTH-1:0] pv;
            k   = start + (t - 1) / (dv + 1);
            ch  = k % CHANNELS;
            stb = ((t - 1) % (dv + 1) == 0) && (k % CHANNELS == 0) && (k > start);
            pv  = blank ? '0 : data_model[ch];
            exp_q.push_back({stb, 8'(ch), pv});
        end
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check({tag, ".chan"},   32'(out_chan),     32'(e[WIDTH +: 8]));
            check({tag, ".port"},   32'(out_port),     32'(e[WIDTH-1:0]));
            check({tag, ".strobe"}, 32'(frame_strobe), 32'(e[QW-1]));
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int dv;
        int st;

        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        for (int i = 0; i < CHANNELS; i++) data_model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst.port",   32'(out_port),     32'h0);
        check("rst.chan",   32'(out_chan),     32'h0);
        check("rst.strobe", 32'(frame_strobe), 32'h0);
        for (int a = 0; a < 8; a++) read_check(AW'(a), 32'h0, "rst.read");

        // Static mode, with junk in the unused upper writedata bits
        write_data(2, 32'hFFFF_FFEA);
        bus_write(A_CTRL, 32'h0000_0200);
        @(posedge clk);
        #1;
        check("static.port", 32'(out_port), 32'h2A);
        check("static.chan", 32'(out_chan), 32'h02);
        read_check(A_STATUS, 32'h0000_0002, "static.status");
        read_check(A_CTRL,   32'h0000_0200, "static.ctrl");
        read_check(AW'(6),   32'h0000_002A, "static.data2");

        // Out-of-range static select
        bus_write(A_CTRL, 32'h0000_0900);
        @(posedge clk);
        #1;
        check("oor.port", 32'(out_port), 32'h0);
        check("oor.chan", 32'(out_chan), 32'h9);

        // Directed scan, DIV=2, two full frames
        write_data(0, 32'h01);
        write_data(1, 32'h02);
        write_data(2, 32'h04);
        write_data(3, 32'h08);
        bus_write(A_DIV, 32'd2);
        read_check(A_DIV, 32'd2, "div.read");
        bus_write(A_CTRL, 32'h0000_0001);
        run_scan_check(0, 2, 26, 1'b0, "scan");
        bus_write(A_CTRL, 32'h0);
        read_check(A_STATUS, 32'h0000_0100, "frame.set");
        bus_write(A_STATUS, 32'h0000_0100);
        read_check(A_STATUS, 32'h0000_0000, "frame.clr");

        // Randomized scans (first one with DIV=0)
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < CHANNELS; i++) write_data(i, $urandom);
            dv = (it == 0) ? 0 : int'($urandom_range(1, 4));
            st = int'($urandom_range(0, CHANNELS - 1));
            bus_write(A_DIV, 32'(dv));
            bus_write(A_CTRL, (32'(st) << 8) | 32'h1);
            run_scan_check(st, dv, 30, 1'b0, "rscan");
            bus_write(A_CTRL, 32'h0);
        end

        // Out-of-range SEL at scan start begins at channel 0
        bus_write(A_DIV, 32'd1);
        bus_write(A_CTRL, 32'h0000_0701);
        run_scan_check(0, 1, 12, 1'b0, "oorstart");
        bus_write(A_CTRL, 32'h0);

        // DIV write landing on a terminal-count cycle
        bus_write(A_DIV, 32'd2);
        bus_write(A_CTRL, 32'h0000_0001);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("divwr.pre", 32'(out_chan), 32'h0);
        end
        bus_write(A_DIV, 32'd5);
        run_scan_check(0, 5, 14, 1'b0, "divwr");
        bus_write(A_CTRL, 32'h0);

        // FRAME set and W1C in the same cycle: set wins
        bus_write(A_STATUS, 32'h0000_0100);
        bus_write(A_DIV, 32'd0);
        bus_write(A_CTRL, 32'h0000_0001);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus_write(A_STATUS, 32'h0000_0100);
        read_check(A_STATUS, 32'h0000_0100, "frame.race");
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h0000_0100);
        read_check(A_STATUS, 32'h0000_0000, "frame.race_clr");

        // BLANK during a scan
        for (int i = 0; i < CHANNELS; i++) write_data(i, 32'($urandom_range(1, 63)));
        bus_write(A_DIV, 32'd1);
        bus_write(A_CTRL, 32'h0000_0003);
        run_scan_check(0, 1, 12, 1'b1, "blank");
        bus_write(A_CTRL, 32'h0);

        // Reset on the edge right after a wrap: no frame_strobe may escape
        bus_write(A_DIV, 32'd1);
        bus_write(A_CTRL, 32'h0000_0001);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mrst.port",   32'(out_port),     32'h0);
        check("mrst.chan",   32'(out_chan),     32'h0);
        check("mrst.strobe", 32'(frame_strobe), 32'h0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("mrst.hold_chan",   32'(out_chan),     32'h0);
            check("mrst.hold_strobe", 32'(frame_strobe), 32'h0);
            check("mrst.hold_port",   32'(out_port),     32'h0);
        end
        read_check(A_CTRL,   32'h0, "mrst.ctrl");
        read_check(A_DIV,    32'h0, "mrst.div");
        read_check(A_STATUS, 32'h0, "mrst.status");
        read_check(AW'(4),   32'h0, "mrst.data0");

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
